// File: rtl/add_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_pipe_pkg
//  Description : Shared constants and helpers for the add_pipe block:
//                pipeline depth bounds, operand/result width legality check
//                and saturation limits for a signed result of a given width.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_pipe_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Result must hold zext(a) (A_W+1 signed bits) or b, plus one bit of headroom
  // so that a plain add can never overflow.
  function automatic bit width_ok(input int a_w, input int b_w, input int c_w);
    int need;
    need = (((a_w + 1) > b_w) ? (a_w + 1) : b_w) + 1;
    return (c_w >= need);
  endfunction

  function automatic bit stages_ok(input int s);
    return (s >= STAGES_MIN) && (s <= STAGES_MAX);
  endfunction

  // Largest positive value of a c_w-bit two's complement number.
  function automatic logic signed [63:0] sat_max(input int c_w);
    return (64'sd1 <<< (c_w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a c_w-bit two's complement number.
  function automatic logic signed [63:0] sat_min(input int c_w);
    return -(64'sd1 <<< (c_w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : add_pipe_stage
//  Description : One delay stage of the add_pipe result pipeline: a valid bit
//                and a data word, both loaded only while en is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_pipe_stage #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Register the upstream beat whenever the pipeline advances; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : add_pipe
//  Description : Pipelined adder of an unsigned operand a and a signed operand
//                b, with an optional running accumulator, sticky overflow flag
//                and valid/ready handshakes on both sides. The whole pipeline
//                stalls globally when the output is held.
//  Config      : ADD_PIPE_SAT_EN - when defined, accumulator overflow
//                saturates the result; otherwise it wraps modulo 2^C_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int A_W    = 21,
  parameter int B_W    = 18,
  parameter int C_W    = 23,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_W-1:0]        a,
  input  logic signed [B_W-1:0] b,
  input  logic                  acc_mode,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [C_W-1:0] c,
  output logic                  ovf
);

  // Parameter legality, reported at elaboration.
  generate
    if (!width_ok(A_W, B_W, C_W)) begin : g_bad_width
      $error("add_pipe: C_W must be at least max(A_W+1, B_W)+1");
    end
    if (!stages_ok(STAGES)) begin : g_bad_stages
      $error("add_pipe: STAGES out of legal range");
    end
  endgenerate

`ifdef ADD_PIPE_SAT_EN
  localparam logic [C_W-1:0] SAT_MAX = C_W'(sat_max(C_W));
  localparam logic [C_W-1:0] SAT_MIN = C_W'(sat_min(C_W));
`endif

  logic           advance;
  logic           accept;
  logic [C_W-1:0] a_ext;
  logic [C_W-1:0] b_ext;
  logic [C_W-1:0] sum;
  logic [C_W-1:0] acc;
  logic [C_W-1:0] acc_base;
  logic [C_W-1:0] acc_sum;
  logic           ovf_base;
  logic [C_W-1:0] r;
  logic           ovf_now;
  logic           s1_valid;
  logic [C_W-1:0] s1_data;
  logic           stage_valid [STAGES];
  logic [C_W-1:0] stage_data  [STAGES];

  // Global stall: everything moves together whenever the output slot frees up.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  assign a_ext = {{(C_W-A_W){1'b0}}, a};
  assign b_ext = {{(C_W-B_W){b[B_W-1]}}, b};
  assign sum   = a_ext + b_ext;

  // A clear in the same cycle as a beat makes that beat start from zero.
  assign acc_base = clr ? '0 : acc;
  assign ovf_base = clr ? 1'b0 : ovf;
  assign acc_sum  = acc_base + sum;

  // Stage-1 result: plain sum, or running sum with signed-overflow detection.
  always_comb begin
    r       = sum;
    ovf_now = 1'b0;
    if (acc_mode) begin
      r       = acc_sum;
      ovf_now = (acc_base[C_W-1] == sum[C_W-1]) && (acc_sum[C_W-1] != sum[C_W-1]);
`ifdef ADD_PIPE_SAT_EN
      if (ovf_now) begin
        r = sum[C_W-1] ? SAT_MIN : SAT_MAX;
      end
`endif
    end
  end

  // Accumulator and sticky overflow: updated on every accepted beat, cleared by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= r;
      ovf <= ovf_base | ovf_now;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end
  end

  // First pipeline register captures the stage-1 result of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= r;
      end
    end
  end

  assign stage_valid[0] = s1_valid;
  assign stage_data[0]  = s1_data;

  // Remaining stages carry the stage-1 result unchanged.
  generate
    for (genvar i = 1; i < STAGES; i++) begin : g_stage
      add_pipe_stage #(
        .W (C_W)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (advance),
        .in_valid  (stage_valid[i-1]),
        .in_data   (stage_data[i-1]),
        .out_valid (stage_valid[i]),
        .out_data  (stage_data[i])
      );
    end
  endgenerate

  assign out_valid = stage_valid[STAGES-1];
  assign c         = stage_data[STAGES-1];

endmodule
`default_nettype wire

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL have parameter A_W, default 21, width of the unsigned operand a.
REQ-002 SHALL have parameter B_W, default 18, width of the signed operand b.
REQ-003 SHALL have parameter C_W, default 23, width of the signed result c; legal only if C_W >= max(A_W+1, B_W)+1 (elaboration error otherwise).
REQ-004 SHALL have parameter STAGES, default 2, pipeline depth; legal range 1..4.
REQ-005 SHALL have ports:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  in_valid  in  1  operand beat valid.
  in_ready  out  1  block accepts a beat this cycle.
  a  in  A_W  unsigned operand.
  b  in  B_W  signed operand.
  acc_mode  in  1  sampled with the beat; 1 = accumulate, 0 = plain add.
  clr  in  1  synchronous clear of the accumulator and ovf.
  out_valid  out  1  result beat valid.
  out_ready  in  1  downstream accepts the result.
  c  out  C_W  signed result.
  ovf  out  1  sticky accumulator overflow flag.

Function
REQ-006 SHALL form sum = zero-extend(a) + sign-extend(b) at C_W bits; plain-add results SHALL never overflow.
REQ-007 SHALL accept a beat when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-008 SHALL advance the whole pipeline when out_ready || !out_valid; in_ready SHALL equal that advance condition (global stall, no bubbles lost, no beat dropped or duplicated).
REQ-009 SHALL present the result of an accepted beat on c/out_valid exactly STAGES cycles after acceptance when out_ready is held high.
REQ-010 SHALL hold c and out_valid stable while out_valid && !out_ready.
REQ-011 Stage 1 SHALL compute r = sum when acc_mode = 0, and r = acc + sum when acc_mode = 1; on acceptance acc SHALL be loaded with r in both modes.
REQ-012 Accumulator overflow (r exceeds the signed C_W range) SHALL set ovf, which stays set until clr or reset.
REQ-013 clr SHALL zero acc and ovf at the next edge, independent of the handshake; with a simultaneous accepted beat, r SHALL use acc = 0 and ovf SHALL reflect only that beat.
REQ-014 The stage-1 result SHALL pass unchanged through the remaining STAGES-1 registers; beats SHALL leave in acceptance order.

Reset
REQ-015 On rst_n low, all stage valids, out_valid, c, acc and ovf SHALL clear to 0 immediately; in_ready SHALL read 1 during and after reset.
REQ-016 Reset mid-stream SHALL discard all in-flight beats; the first beat after release SHALL behave as if following clr.

Configuration
REQ-017 Macro ADD_PIPE_SAT_EN defined: on accumulator overflow, r SHALL saturate to +(2^(C_W-1))-1 or -(2^(C_W-1)).
REQ-018 Macro ADD_PIPE_SAT_EN undefined: r SHALL wrap modulo 2^C_W; ovf behaviour is identical in both builds.

Structure
REQ-019 Package add_pipe_pkg SHALL hold the STAGES bounds, the width-legality check function and saturation min/max helper functions.
REQ-020 One sub-module add_pipe_stage (valid + C_W data register, enable-controlled) SHALL be instantiated STAGES-1 times.

Verification
REQ-021 Defaults, b = 0, a stepping 1..80 one beat per cycle, out_ready = 1 -> c = 1..80 in order, each 2 cycles after its accept.
REQ-022 a = 0x1FFFFF, b = -131072, acc_mode = 0 -> c = 1966079, ovf = 0.
REQ-023 out_ready low for 5 cycles with continuous input -> in_ready falls once both stages are full, c held stable, no beat lost or duplicated after release.
REQ-024 acc_mode = 1, a = 0x1FFFFF, b = 0, three beats -> c = 2097151, 4194302, then -2097155 with wrap or 4194303 with ADD_PIPE_SAT_EN; ovf = 1 after the third beat.
REQ-025 clr asserted together with an accepted accumulate beat a = 5, b = -7 -> c = -2, ovf = 0.
REQ-026 rst_n pulsed low with 2 beats in flight -> out_valid = 0 immediately, and neither beat appears after release.
